// File: rtl/ternary_dot_engine_if.sv
// Stream bundle for the ternary dot engine: input beat channel and result channel.
interface ternary_dot_engine_if #(
  parameter int LANES = 4,
  parameter int IN_W  = 2,
  parameter int ACC_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IN_W-1:0]   in_data;
  logic [LANES*2-1:0]      in_weight;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ternary_dot_engine.sv
// Sequenced multi-lane ternary dot product: bias + sum over BEATS beats of
// LANES activation*weight products, saturating or wrapping, with optional ReLU.
module ternary_dot_engine #(
  parameter int LANES = 4,
  parameter int IN_W  = 2,
  parameter int ACC_W = 8,
  parameter int BEATS = 4,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    relu_en,
  ternary_dot_engine_if.slave     s,
  output logic                    busy,
  output logic                    sat_flag
);

  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W  = $clog2(LANES * ((1 << IN_W) - 1) + 1) + 1;
  localparam int FULL_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic signed [FULL_W-1:0] MAX_F =
    {{(FULL_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] MIN_F = ~MAX_F;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    relu_q;
  logic                    xfer;
  logic                    last_beat;
  logic signed [SUM_W-1:0] beat_sum;
  logic signed [FULL_W-1:0] acc_full;
  logic [ACC_W:0]          acc_next;

  // 00 and reserved 10 contribute nothing; 01 adds, 11 subtracts.
  function automatic logic signed [SUM_W-1:0] lane_prod(input logic [IN_W-1:0] a,
                                                        input logic [1:0]      w);
    logic signed [SUM_W-1:0] ax;
    ax = {{(SUM_W-IN_W){1'b0}}, a};
    case (w)
      2'b01:   return ax;
      2'b11:   return -ax;
      default: return '0;
    endcase
  endfunction

  // Returns {overflow, result}: clamp when SAT is set, otherwise wrap and flag.
  function automatic logic [ACC_W:0] sat_or_wrap(input logic signed [FULL_W-1:0] full);
    logic [ACC_W-1:0] trunc;
    trunc = full[ACC_W-1:0];
    if (SAT != 0) begin
      if (full > MAX_F)      return {1'b1, MAX_F[ACC_W-1:0]};
      else if (full < MIN_F) return {1'b1, MIN_F[ACC_W-1:0]};
      else                   return {1'b0, trunc};
    end else begin
      return {(full != {{(FULL_W-ACC_W){trunc[ACC_W-1]}}, trunc}), trunc};
    end
  endfunction

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++)
      beat_sum = beat_sum + lane_prod(s.in_data[i*IN_W +: IN_W], s.in_weight[2*i +: 2]);
  end

  assign acc_full  = {{(FULL_W-ACC_W){acc[ACC_W-1]}}, acc}
                   + {{(FULL_W-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};
  assign acc_next  = sat_or_wrap(acc_full);
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
  assign xfer      = s.in_valid && s.in_ready;
  assign s.out_data = (relu_q && acc[ACC_W-1]) ? '0 : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        s.in_ready = 1'b1;
        busy       = 1'b1;
        if (s.in_valid && last_beat) state_d = OUT;
      end
      OUT: begin
        s.out_valid = 1'b1;
        busy        = 1'b1;
        if (s.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      relu_q   <= 1'b0;
      sat_flag <= 1'b0;
    end else if (state_q == IDLE && start) begin
      acc      <= bias;
      beat_cnt <= '0;
      relu_q   <= relu_en;
      sat_flag <= 1'b0;
    end else if (xfer) begin
      acc      <= $signed(acc_next[ACC_W-1:0]);
      beat_cnt <= beat_cnt + CNT_W'(1);
      sat_flag <= sat_flag | acc_next[ACC_W];
    end
  end

endmodule

// File: tb/tb_ternary_dot_engine.sv
// Directed bench for ternary_dot_engine: saturating and wrapping instances run in lockstep.
module tb_ternary_dot_engine;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic signed [7:0]      bias;
  logic                   relu_en;
  logic                   in_valid;
  logic [7:0]             in_data;
  logic [7:0]             in_weight;
  logic                   out_ready;
  logic                   busy1, busy0, sf1, sf0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ternary_dot_engine_if #(.LANES(4), .IN_W(2), .ACC_W(8)) if1 ();
  ternary_dot_engine_if #(.LANES(4), .IN_W(2), .ACC_W(8)) if0 ();

  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.in_weight = in_weight;
  assign if1.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.in_weight = in_weight;
  assign if0.out_ready = out_ready;

  ternary_dot_engine #(.LANES(4), .IN_W(2), .ACC_W(8), .BEATS(4), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .relu_en(relu_en),
    .s(if1.slave), .busy(busy1), .sat_flag(sf1)
  );

  ternary_dot_engine #(.LANES(4), .IN_W(2), .ACC_W(8), .BEATS(4), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .relu_en(relu_en),
    .s(if0.slave), .busy(busy0), .sat_flag(sf0)
  );

  typedef struct {
    logic signed [7:0] bias;
    logic              relu;
    logic [3:0][7:0]   data;
    logic [3:0][7:0]   wt;
    logic signed [7:0] exp1;
    logic              esf1;
    logic signed [7:0] exp0;
    logic              esf0;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_dot(input int idx, input int gap, input int hold, input bit poke);
    int cyc;
    int n;
    @(negedge clk);
    bias    = vt[idx].bias;
    relu_en = vt[idx].relu;
    start   = 1'b1;
    @(negedge clk);
    cyc     = 1;
    start   = 1'b0;
    bias    = 8'sd99;
    relu_en = ~vt[idx].relu;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        start = poke;
        @(negedge clk);
        cyc++;
        start = 1'b0;
      end
      in_valid  = 1'b1;
      in_data   = vt[idx].data[b];
      in_weight = vt[idx].wt[b];
      n = 0;
      while (!if1.in_ready && n < 20) begin
        @(negedge clk);
        n++;
        cyc++;
      end
      chk("in_ready", int'(if1.in_ready), 1);
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
    end
    n = 0;
    while (!if1.out_valid && n < 50) begin
      @(negedge clk);
      n++;
      cyc++;
    end
    chk("out_valid", int'(if1.out_valid), 1);
    if (gap == 0) chk("latency", cyc, 5);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_data", int'(if1.out_data), int'(vt[idx].exp1));
      chk("hold_valid", int'(if1.out_valid), 1);
      start = poke;
      @(negedge clk);
      start = 1'b0;
    end
    chk("data_sat", int'(if1.out_data), int'(vt[idx].exp1));
    chk("flag_sat", int'(sf1), int'(vt[idx].esf1));
    chk("data_wrap", int'(if0.out_data), int'(vt[idx].exp0));
    chk("flag_wrap", int'(sf0), int'(vt[idx].esf0));
    chk("busy_out", int'(busy1), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", int'(if1.out_valid), 0);
    chk("busy_idle", int'(busy1), 0);
    chk("flag_kept", int'(sf1), int'(vt[idx].esf1));
  endtask

  initial begin
    vt[0] = '{8'sd0,   1'b0, {4{8'hFF}}, {4{8'h55}}, 8'sd48,  1'b0, 8'sd48,   1'b0};
    vt[1] = '{8'sd5,   1'b0, {4{8'hFF}}, {4{8'hFF}}, -8'sd43, 1'b0, -8'sd43,  1'b0};
    vt[2] = '{8'sd5,   1'b1, {4{8'hFF}}, {4{8'hFF}}, 8'sd0,   1'b0, 8'sd0,    1'b0};
    vt[3] = '{8'sd120, 1'b0, {4{8'hFF}}, {8'h00, 8'h00, 8'hFF, 8'h55},
              8'sd115, 1'b1, 8'sd120, 1'b1};
    vt[4] = '{-8'sd1,  1'b0, {4{8'h9B}}, {4{8'h2D}}, 8'sd3,   1'b0, 8'sd3,    1'b0};

    rst_n = 1'b0; start = 1'b0; bias = '0; relu_en = 1'b0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(if1.in_ready), 0);
    chk("rst_out_valid", int'(if1.out_valid), 0);
    chk("rst_out_data", int'(if1.out_data), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_sat_flag", int'(sf1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_dot(i, 0, 0, 1'b0);

    run_dot(0, 2, 3, 1'b1);

    // Abort mid-operation with a reset after two beats.
    @(negedge clk);
    bias = 8'sd100; relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; in_weight = 8'h55;
    repeat (2) @(negedge clk);
    chk("mid_busy", int'(busy1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy1), 0);
    chk("mid_rst_in_ready", int'(if1.in_ready), 0);
    chk("mid_rst_out_valid", int'(if1.out_valid), 0);
    chk("mid_rst_out_data", int'(if1.out_data), 0);
    chk("mid_rst_sat_flag", int'(sf1), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_dot(0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ternary_dot_engine.md
Name: ternary_dot_engine

Overview:
Multi-lane, sequenced ternary dot-product engine. Each accepted beat carries LANES unsigned activations and LANES ternary weights. The engine accumulates one full dot product over BEATS beats, starting from a bias, then presents the result with optional ReLU. It replaces per-element ternary MAC chaining in the layer datapath: an input stream feeds it and a result stream drains to the activation/requant stage.

Parameters:
LANES, 4, activation/weight pairs processed per beat
IN_W, 2, unsigned activation width per lane
ACC_W, 8, signed accumulator and result width
BEATS, 4, beats per dot product (≥1); counter width is clog2(BEATS), minimum 1
SAT, 1, 1 = saturating accumulate; 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a dot product (accepted only in IDLE)
bias  in  ACC_W  signed initial accumulator value, sampled with accepted start
relu_en  in  1  sampled with accepted start; clamps negative result to 0
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts a beat
in_data  in  LANES*IN_W  packed activations; lane i = bits [i*IN_W +: IN_W]
in_weight  in  LANES*2  packed ternary weights; lane i = bits [2i +: 2]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  signed result
busy  out  1  high in ACCUM or OUT
sat_flag  out  1  sticky saturation indicator for the current/last dot product

Behaviour:
- Reset (asynchronous, active-low; applies at any time, including mid-operation):
  - State → IDLE; acc, beat_cnt, relu_q, sat_flag cleared.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - A partially accumulated dot product is discarded.
- Weight decode: 00→0, 01→+1, 11→−1, 10→0 (reserved).
- Lane product: activation zero-extended, then negated or zeroed per weight.
- Beat sum: signed sum of all lane products. Width must hold ±LANES*(2^IN_W−1) without overflow.
- Accumulate: the exact sum acc+beat_sum is formed at full width.
  - SAT=1: clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1]; set sat_flag on clamp.
  - SAT=0: truncate to ACC_W bits; set sat_flag on signed overflow.
- FSM:
  - IDLE: in_ready=0. On start=1: acc←bias, relu_q←relu_en, beat_cnt←0, sat_flag←0, go to ACCUM.
  - ACCUM: in_ready=1. A beat transfers when in_valid&in_ready; idle cycles when in_valid=0 are allowed. On transfer, acc updates and beat_cnt increments. On the transfer with beat_cnt==BEATS−1, go to OUT.
  - OUT: out_valid=1; out_data = (relu_q && acc<0) ? 0 : acc, held stable while out_ready=0. On out_ready=1, go to IDLE (out_valid falls next cycle).
- Latency: out_valid rises the cycle after the final beat transfer.
  - Minimum start-to-result is BEATS+1 cycles.
  - Back-to-back throughput: one dot product per BEATS+2 cycles.
- start is ignored in ACCUM and OUT (no restart, no bias reload). start and bias are don't-care outside IDLE.
- in_ready is combinational from state only; it never depends on in_valid.
- sat_flag holds its value through OUT and IDLE until the next accepted start.
- out_data retains its last value after handshake; only out_valid qualifies it.

Test Plan:
- Defaults; bias=0; 4 beats, all activations 3, all weights 01 → out_data=48, sat_flag=0, out_valid exactly 5 cycles after start.
- bias=5, all activations 3, all weights 11, relu_en=0 → out_data=−43 (0xD5). Repeat with relu_en=1 → out_data=0.
- Saturation: bias=120, beat0 all +1×3 (+12); beat1 all −1×3 (−12); beats 2–3 weights 00 → acc clamps 127 then 115; out_data=115, sat_flag=1. With SAT=0, the same stimulus wraps to −124 then returns to 120; sat_flag=1.
- Mixed/reserved weights: lanes (act,w)=(3,01),(2,11),(1,10),(2,00) on every beat, bias=−1 → out_data=3 (4×1 − 1).
- Handshake: in_valid gaps of 2 cycles between beats, out_ready low for 3 cycles → out_data stable; start pulsed during ACCUM and during OUT is ignored; result still 48 for the first-scenario stimulus.
- rst_n asserted after 2 beats → outputs clear immediately; a new start with bias=0 and the first-scenario stimulus → out_data=48 (no residue).
